// File: rtl/lsu_mem_stage.sv
// Load/store unit sitting between the core memory stage and a synchronous data RAM.
// Accepts one byte/half/word access, checks its alignment, drives the RAM with a
// word-aligned address, byte enables and lane-replicated data, and returns the
// extended load data. stall holds the upstream pipeline until the access completes.
module lsu_mem_stage #(
    parameter int unsigned RD_LAT = 1  // RAM read latency, legal 1..7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        addr_err,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        signed_q;
    logic        err_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [2:0]  cnt_q;

    logic        req_bad;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [31:0] ld_shift;
    logic [31:0] ld_ext;

    // Alignment check on the incoming request; size 11 is always rejected.
    always_comb begin
        req_bad = 1'b0;
        unique case (req_size)
            2'b00:   req_bad = 1'b0;
            2'b01:   req_bad = req_addr[0];
            2'b10:   req_bad = (req_addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    // Byte enables and replicated store data from the latched request.
    always_comb begin
        st_mask = 4'b1111;
        st_data = wdata_q;
        unique case (size_q)
            2'b00: begin
                st_mask = 4'b0001 << addr_q[1:0];
                st_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_mask = 4'b0011 << {addr_q[1], 1'b0};
                st_data = {2{wdata_q[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = wdata_q;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension; a half is aligned, so a byte-granular
    // shift lands it in the low lanes as well.
    always_comb begin
        ld_shift = ram_rdata >> {addr_q[1:0], 3'b000};
        ld_ext   = ram_rdata;
        unique case (size_q)
            2'b00:   ld_ext = {{24{signed_q & ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_ext = {{16{signed_q & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_ext = ram_rdata;
        endcase
    end

    // Next-state and outputs; outputs decode from state so reset clears them at once.
    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        addr_err  = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = 32'h0;
        ram_wdata = 32'h0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    stall   = 1'b1;
                    state_d = req_bad ? StResp : StIssue;
                end
            end
            StIssue: begin
                stall     = 1'b1;
                ram_en    = 1'b1;
                ram_addr  = {addr_q[31:2], 2'b00};
                ram_we    = we_q ? st_mask : 4'b0000;
                ram_wdata = st_data;
                state_d   = we_q ? StResp : StWait;
            end
            StWait: begin
                stall = 1'b1;
                if (cnt_q == 3'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                // req_valid here still belongs to the access being finished.
                rsp_valid = 1'b1;
                addr_err  = err_q;
                rsp_rdata = rdata_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register, request capture, read-latency counter and load data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= 32'h0;
            size_q   <= 2'b00;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            cnt_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req_valid) begin
                addr_q   <= req_addr;
                size_q   <= req_size;
                we_q     <= req_we;
                signed_q <= req_signed;
                wdata_q  <= req_wdata;
                err_q    <= req_bad;
                rdata_q  <= 32'h0;
            end
            if (state_q == StIssue) begin
                cnt_q <= 3'(RD_LAT);
            end else if (state_q == StWait) begin
                cnt_q <= cnt_q - 3'd1;
            end
            if (state_q == StWait && cnt_q == 3'd1) begin
                rdata_q <= ld_ext;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: a RAM model with configurable read latency, a shadow memory
// reference model, directed scenarios and a randomized access stream.
module tb_lsu_mem_stage;

    localparam int RD_LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        addr_err;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .addr_err   (addr_err),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // RAM model: 64 words, byte writes, read data valid RD_LAT edges after the enable edge.
    logic        poke = 1'b0;
    logic [5:0]  poke_idx = 6'd0;
    logic [31:0] poke_val = 32'h0;
    logic [31:0] ram [0:63];
    logic [31:0] rd_pipe [0:RD_LAT-1];

    always @(posedge clk) begin
        if (poke) begin
            ram[poke_idx] <= poke_val;
        end else if (ram_en) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_we[i]) ram[ram_addr[7:2]][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
        rd_pipe[0] <= (ram_en && ram_we == 4'b0000) ? ram[ram_addr[7:2]] : 32'h0;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RD_LAT-1];

    // Reference model state and helpers.
    logic [31:0] ref_mem [0:63];

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_bad(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
        return (addr % nbytes(size)) != 0;
    endfunction

    function automatic int exp_lat(input logic we, input logic [1:0] size, input logic [31:0] addr);
        if (is_bad(size, addr)) return 1;
        return we ? 2 : 2 + RD_LAT;
    endfunction

    function automatic logic [3:0] exp_mask(input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] m = 4'b0000;
        int off = int'(addr % 4);
        for (int i = 0; i < 4; i++) if (i >= off && i < off + nbytes(size)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d = 32'h0;
        int n = nbytes(size);
        for (int i = 0; i < 4; i++) d = d | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [1:0] size,
                                             input logic sgn, input logic [31:0] addr);
        int          n = nbytes(size);
        logic [31:0] v = word >> (8 * (addr % 4));
        logic [31:0] lo;
        if (n < 4) begin
            lo = (32'h1 << (8 * n)) - 1;
            v  = v & lo;
            if (sgn && ((v >> (8 * n - 1)) & 32'h1) != 0) v = v | ~lo;
        end
        return v;
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wd);
        logic [3:0]  m   = exp_mask(size, addr);
        logic [31:0] rep = exp_wdata(size, wd);
        int          idx = int'((addr >> 2) % 64);
        for (int i = 0; i < 4; i++) begin
            if (m[i]) ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << (8 * i))) | (rep & (32'hFF << (8 * i)));
        end
    endtask

    task automatic poke_word(input int idx, input logic [31:0] val);
        poke = 1'b1; poke_idx = 6'(idx); poke_val = val;
        @(posedge clk); #1;
        poke = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Observations gathered by run_access for the calling test to judge.
    bit          obs_got;
    int          obs_lat, obs_en_cnt, obs_en_at, obs_stall_cnt, obs_spur;
    logic        obs_err, obs_stall_rsp;
    logic [3:0]  obs_we;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;

    // Drives one request from the current cycle (entered at posedge+1) and records activity.
    task automatic run_access(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wd, input bit gap);
        obs_got = 0; obs_lat = -1; obs_en_cnt = 0; obs_en_at = -1; obs_stall_cnt = 0;
        obs_spur = 0; obs_err = 0; obs_stall_rsp = 1'b1; obs_we = 0; obs_addr = 0;
        obs_wdata = 0; obs_rdata = 32'hX;
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wd;
        for (int c = 0; c < 16 && !obs_got; c++) begin
            @(negedge clk);
            if (ram_en) begin
                obs_en_cnt++; obs_en_at = c; obs_we = ram_we; obs_addr = ram_addr;
                obs_wdata = ram_wdata;
            end else if (ram_we != 4'b0000) begin
                obs_spur++;
            end
            if (rsp_valid) begin
                obs_got = 1; obs_lat = c; obs_rdata = rsp_rdata; obs_err = addr_err;
                obs_stall_rsp = stall;
            end else begin
                if (stall) obs_stall_cnt++;
                if (rsp_rdata != 32'h0 || addr_err) obs_spur++;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (gap) begin
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                if (stall || ram_en || rsp_valid || ram_we != 4'b0000) obs_spur++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if ({stall, rsp_valid, addr_err, ram_en, ram_we, ram_addr, ram_wdata, rsp_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stall=%b rsp=%b err=%b en=%b we=%b addr=%h wd=%h rd=%h want all 0",
                     stall, rsp_valid, addr_err, ram_en, ram_we, ram_addr, ram_wdata, rsp_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({stall, rsp_valid, ram_en} !== 3'b000) begin
            n_fail++; $display("FAIL reset_idle: got stall/rsp/en=%b%b%b want 000", stall, rsp_valid, ram_en);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        run_access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
        model_store(2'd2, 32'h10, 32'hDEADBEEF);
        n_tests++; if (obs_en_at !== 1 || obs_en_cnt !== 1) begin n_fail++; $display("FAIL sw_en: got at=%0d cnt=%0d want 1/1", obs_en_at, obs_en_cnt); end
        n_tests++; if (obs_we !== 4'b1111) begin n_fail++; $display("FAIL sw_we: got %b want 1111", obs_we); end
        n_tests++; if (obs_addr !== 32'h10) begin n_fail++; $display("FAIL sw_addr: got %h want 00000010", obs_addr); end
        n_tests++; if (obs_lat !== 2 || obs_stall_rsp !== 1'b0) begin n_fail++; $display("FAIL sw_rsp: got lat=%0d stall=%b want 2/0", obs_lat, obs_stall_rsp); end
        n_tests++; if (obs_stall_cnt !== 2 || obs_spur !== 0) begin n_fail++; $display("FAIL sw_stall: got stall_cyc=%0d spur=%0d want 2/0", obs_stall_cnt, obs_spur); end
        run_access(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 1'b1);
        model_store(2'd0, 32'h13, 32'h000000A5);
        n_tests++; if (obs_we !== 4'b1000) begin n_fail++; $display("FAIL sb_we: got %b want 1000", obs_we); end
        n_tests++; if (obs_wdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h want a5a5a5a5", obs_wdata); end
        n_tests++; if (obs_addr !== 32'h10) begin n_fail++; $display("FAIL sb_addr: got %h want 00000010", obs_addr); end
    endtask

    task automatic test_load();
        poke_word(4, 32'h1280FF00);
        run_access(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 1'b1);
        n_tests++; if (obs_lat !== 2 + RD_LAT) begin n_fail++; $display("FAIL lb_lat: got %0d want %0d", obs_lat, 2 + RD_LAT); end
        n_tests++; if (obs_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_rdata: got %h want ffffff80", obs_rdata); end
        n_tests++; if (obs_we !== 4'b0000 || obs_en_at !== 1) begin n_fail++; $display("FAIL lb_en: got we=%b at=%0d want 0000/1", obs_we, obs_en_at); end
        run_access(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 1'b1);
        n_tests++; if (obs_rdata !== 32'h00000080) begin n_fail++; $display("FAIL lbu_rdata: got %h want 00000080", obs_rdata); end
        poke_word(8, 32'h80017FFF);
        run_access(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1'b1);
        n_tests++; if (obs_rdata !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_rdata: got %h want ffff8001", obs_rdata); end
        n_tests++; if (obs_stall_cnt !== 2 + RD_LAT || obs_stall_rsp !== 1'b0) begin n_fail++; $display("FAIL lh_stall: got cyc=%0d rsp_stall=%b want %0d/0", obs_stall_cnt, obs_stall_rsp, 2 + RD_LAT); end
        run_access(1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 1'b1);
        n_tests++; if (obs_rdata !== 32'h00007FFF) begin n_fail++; $display("FAIL lhu_rdata: got %h want 00007fff", obs_rdata); end
    endtask

    task automatic test_error();
        logic [1:0]  sz [3] = '{2'd2, 2'd3, 2'd1};
        logic [31:0] ad [3] = '{32'h06, 32'h00, 32'h01};
        for (int k = 0; k < 3; k++) begin
            run_access(1'b0, sz[k], 1'b1, ad[k], 32'h0, 1'b1);
            n_tests++;
            if (obs_lat !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_en_cnt !== 0 || obs_spur !== 0) begin
                n_fail++;
                $display("FAIL err_%0d: got lat=%0d err=%b rd=%h en=%0d spur=%0d want 1/1/0/0/0",
                         k, obs_lat, obs_err, obs_rdata, obs_en_cnt, obs_spur);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd = $urandom;
        run_access(1'b1, 2'd2, 1'b0, 32'h44, wd, 1'b0);
        model_store(2'd2, 32'h44, wd);
        n_tests++; if (obs_lat !== 2) begin n_fail++; $display("FAIL b2b_store_lat: got %0d want 2", obs_lat); end
        run_access(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 1'b1);
        n_tests++; if (obs_lat !== 2 + RD_LAT || obs_rdata !== ref_mem[17]) begin n_fail++; $display("FAIL b2b_load: got lat=%0d rd=%h want %0d/%h", obs_lat, obs_rdata, 2 + RD_LAT, ref_mem[17]); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 120; it++) begin
            int          r   = $urandom_range(0, 9);
            logic [1:0]  sz  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            logic        we  = 1'($urandom_range(0, 1));
            logic        sg  = 1'($urandom_range(0, 1));
            logic [31:0] ad  = 32'($urandom_range(0, 255));
            logic [31:0] wd  = $urandom;
            bit          bad = is_bad(sz, ad);
            logic [31:0] erd = 32'h0;
            if (!bad && !we) erd = exp_load(ref_mem[int'((ad >> 2) % 64)], sz, sg, ad);
            run_access(we, sz, sg, ad, wd, 1'($urandom_range(0, 1)));
            if (!bad && we) model_store(sz, ad, wd);
            n_tests++;
            if (obs_lat !== exp_lat(we, sz, ad) || obs_err !== bad || obs_rdata !== erd ||
                obs_stall_cnt !== exp_lat(we, sz, ad) || obs_stall_rsp !== 1'b0 || obs_spur !== 0) begin
                n_fail++;
                $display("FAIL rand_rsp[%0d]: we=%b sz=%0d a=%h got lat=%0d err=%b rd=%h stc=%0d sp=%0d want lat=%0d err=%b rd=%h",
                         it, we, sz, ad, obs_lat, obs_err, obs_rdata, obs_stall_cnt, obs_spur,
                         exp_lat(we, sz, ad), bad, erd);
            end
            n_tests++;
            if (bad ? (obs_en_cnt !== 0) :
                (obs_en_cnt !== 1 || obs_en_at !== 1 || obs_addr !== (ad & ~32'h3) ||
                 obs_we !== (we ? exp_mask(sz, ad) : 4'b0000) ||
                 (we && obs_wdata !== exp_wdata(sz, wd)))) begin
                n_fail++;
                $display("FAIL rand_ram[%0d]: we=%b sz=%0d a=%h got en=%0d at=%0d addr=%h be=%b wd=%h want addr=%h be=%b wd=%h",
                         it, we, sz, ad, obs_en_cnt, obs_en_at, obs_addr, obs_we, obs_wdata,
                         ad & ~32'h3, we ? exp_mask(sz, ad) : 4'b0000, exp_wdata(sz, wd));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] old = ref_mem[12];
        int          bad = 0;
        // Load interrupted while waiting on the RAM.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++; if (stall !== 1'b1 || ram_en !== 1'b0) begin n_fail++; $display("FAIL rst_wait_pre: got stall=%b en=%b want 1/0", stall, ram_en); end
        rst = 1'b1; req_valid = 1'b0; #1;
        n_tests++;
        if ({stall, rsp_valid, addr_err, ram_en, ram_we, ram_addr, ram_wdata, rsp_rdata} !== '0) begin
            n_fail++; $display("FAIL rst_wait_out: got stall=%b rsp=%b en=%b we=%b rd=%h want all 0", stall, rsp_valid, ram_en, ram_we, rsp_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if ({stall, rsp_valid, ram_en} !== 3'b000) begin n_fail++; $display("FAIL rst_wait_idle: got %b%b%b want 000", stall, rsp_valid, ram_en); end
        @(posedge clk); #1;
        // Store interrupted in its RAM issue cycle.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h30; req_wdata = ~old;
        @(posedge clk); #1;
        n_tests++; if (ram_en !== 1'b1 || ram_we !== 4'b1111) begin n_fail++; $display("FAIL rst_issue_pre: got en=%b we=%b want 1/1111", ram_en, ram_we); end
        rst = 1'b1; req_valid = 1'b0; #1;
        n_tests++;
        if ({stall, rsp_valid, addr_err, ram_en, ram_we, ram_addr, ram_wdata, rsp_rdata} !== '0) begin
            n_fail++; $display("FAIL rst_issue_out: got stall=%b en=%b we=%b addr=%h wd=%h want all 0", stall, ram_en, ram_we, ram_addr, ram_wdata);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ram_en || ram_we != 4'b0000) bad++;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL rst_issue_hold: got %0d active cycles want 0", bad); end
        run_access(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b1);
        n_tests++; if (obs_lat !== 2 + RD_LAT || obs_rdata !== old) begin n_fail++; $display("FAIL rst_no_write: got lat=%0d rd=%h want %0d/%h", obs_lat, obs_rdata, 2 + RD_LAT, old); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        for (int i = 0; i < 64; i++) poke_word(i, $urandom);
        test_store();
        test_load();
        test_error();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
